// File: rtl/mul_div_unit.sv
// Iterative MULTU/MULT/DIVU/DIV unit: shift-add multiply and restoring divide, one bit per clock.
// Defining MDU_HILO_WRITE_EN adds an MTHI/MTLO write port (hilo_we/hilo_sel/hilo_wd).
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
`ifdef MDU_HILO_WRITE_EN
    input  logic             hilo_we,
    input  logic             hilo_sel,
    input  logic [WIDTH-1:0] hilo_wd,
`endif
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CALC   = 2'd1,
        S_FINISH = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;
    logic             sign_a_q, sign_a_d;
    logic             sign_b_q, sign_b_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] a_raw_q, a_raw_d;
    logic [WIDTH-1:0] b_mag_q, b_mag_d;
    logic [WIDTH-1:0] work_hi_q, work_hi_d;
    logic [WIDTH-1:0] work_lo_q, work_lo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic [WIDTH:0]     mul_sum_s;
    logic [WIDTH:0]     div_shift_s;
    logic               div_ge_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   res_hi_s, res_lo_s;
    logic               sign_a_in_s, sign_b_in_s;

    // Modulo-2^WIDTH negation also yields the right unsigned magnitude for -2^(WIDTH-1).
    function automatic logic [WIDTH-1:0] cond_negate(input logic [WIDTH-1:0] x, input logic neg);
        if (neg) begin
            return ~x + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            return x;
        end
    endfunction

    assign sign_a_in_s = op[0] & A[WIDTH-1];
    assign sign_b_in_s = op[0] & B[WIDTH-1];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   state_d = start ? S_CALC : S_IDLE;
            S_CALC:   state_d = (cnt_q == CW'(1)) ? S_FINISH : S_CALC;
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Operand capture and one shift-add / restoring-divide step per CALC cycle
    always_comb begin
        mul_sum_s   = {1'b0, work_hi_q} + (work_lo_q[0] ? {1'b0, b_mag_q} : {(WIDTH+1){1'b0}});
        div_shift_s = {work_hi_q, work_lo_q[WIDTH-1]};
        div_ge_s    = (div_shift_s >= {1'b0, b_mag_q});
        cnt_d       = cnt_q;
        op_d        = op_q;
        sign_a_d    = sign_a_q;
        sign_b_d    = sign_b_q;
        dz_d        = dz_q;
        a_raw_d     = a_raw_q;
        b_mag_d     = b_mag_q;
        work_hi_d   = work_hi_q;
        work_lo_d   = work_lo_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cnt_d     = CW'(WIDTH);
                    op_d      = op;
                    sign_a_d  = sign_a_in_s;
                    sign_b_d  = sign_b_in_s;
                    dz_d      = op[1] & (B == {WIDTH{1'b0}});
                    a_raw_d   = A;
                    b_mag_d   = cond_negate(B, sign_b_in_s);
                    work_hi_d = {WIDTH{1'b0}};
                    work_lo_d = cond_negate(A, sign_a_in_s);
                end else begin
                    cnt_d = cnt_q;
                end
            end
            S_CALC: begin
                cnt_d = cnt_q - CW'(1);
                if (!op_q[1]) begin
                    work_hi_d = mul_sum_s[WIDTH:1];
                    work_lo_d = {mul_sum_s[0], work_lo_q[WIDTH-1:1]};
                end else if (div_ge_s) begin
                    work_hi_d = WIDTH'(div_shift_s - {1'b0, b_mag_q});
                    work_lo_d = {work_lo_q[WIDTH-2:0], 1'b1};
                end else begin
                    work_hi_d = div_shift_s[WIDTH-1:0];
                    work_lo_d = {work_lo_q[WIDTH-2:0], 1'b0};
                end
            end
            S_FINISH: cnt_d = cnt_q;
            default:  cnt_d = {CW{1'b0}};
        endcase
    end

    // Sign correction of the magnitude result; divide-by-zero bypasses the datapath
    always_comb begin
        prod_s = {work_hi_q, work_lo_q};
        if (dz_q) begin
            res_hi_s = a_raw_q;
            res_lo_s = {WIDTH{1'b1}};
        end else if (!op_q[1]) begin
            if (sign_a_q ^ sign_b_q) begin
                prod_s = ~prod_s + {{(2*WIDTH-1){1'b0}}, 1'b1};
            end else begin
                prod_s = {work_hi_q, work_lo_q};
            end
            res_hi_s = prod_s[2*WIDTH-1:WIDTH];
            res_lo_s = prod_s[WIDTH-1:0];
        end else begin
            res_lo_s = cond_negate(work_lo_q, sign_a_q ^ sign_b_q);
            res_hi_s = cond_negate(work_hi_q, sign_a_q);
        end
    end

    // Output logic: handshake flags and HI/LO update
    always_comb begin
        busy_d = (state_d != S_IDLE);
        done_d = (state_q == S_FINISH);
        dbz_d  = (state_q == S_FINISH) & dz_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        if (state_q == S_FINISH) begin
            hi_d = res_hi_s;
            lo_d = res_lo_s;
        end
`ifdef MDU_HILO_WRITE_EN
        else if ((state_q == S_IDLE) && hilo_we && !start) begin
            if (hilo_sel) begin
                hi_d = hilo_wd;
            end else begin
                lo_d = hilo_wd;
            end
        end
`endif
        else begin
            hi_d = hi_q;
            lo_d = lo_q;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= {CW{1'b0}};
            op_q      <= 2'b00;
            sign_a_q  <= 1'b0;
            sign_b_q  <= 1'b0;
            dz_q      <= 1'b0;
            a_raw_q   <= {WIDTH{1'b0}};
            b_mag_q   <= {WIDTH{1'b0}};
            work_hi_q <= {WIDTH{1'b0}};
            work_lo_q <= {WIDTH{1'b0}};
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
            hi_q      <= {WIDTH{1'b0}};
            lo_q      <= {WIDTH{1'b0}};
        end else begin
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            sign_a_q  <= sign_a_d;
            sign_b_q  <= sign_b_d;
            dz_q      <= dz_d;
            a_raw_q   <= a_raw_d;
            b_mag_q   <= b_mag_d;
            work_hi_q <= work_hi_d;
            work_lo_q <= work_lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            dbz_q     <= dbz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: reference results from plain 64-bit arithmetic, monitor pops on done.
module tb_mul_div_unit;

    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         busy;
    logic         done;
    logic         div_by_zero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
`ifdef MDU_HILO_WRITE_EN
    logic         hilo_we;
    logic         hilo_sel;
    logic [W-1:0] hilo_wd;
`endif

    int checks = 0;
    int passes = 0;
    logic [64:0] exp_q[$];

    mul_div_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .A(A), .B(B),
`ifdef MDU_HILO_WRITE_EN
        .hilo_we(hilo_we), .hilo_sel(hilo_sel), .hilo_wd(hilo_wd),
`endif
        .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] expv);
        checks++;
        if (act === expv) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, expv);
    endtask

    // Reference: {div_by_zero, hi, lo} from the arithmetic definition of each op
    function automatic logic [64:0] model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        longint      sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            2'd0: begin
                p = {32'd0, a} * {32'd0, b};
                return {1'b0, p};
            end
            2'd1: begin
                p = 64'(sa * sb);
                return {1'b0, p};
            end
            2'd2: begin
                if (b == 32'd0) return {1'b1, a, 32'hFFFFFFFF};
                return {1'b0, a % b, a / b};
            end
            default: begin
                if (b == 32'd0) return {1'b1, a, 32'hFFFFFFFF};
                q = sa / sb;
                r = sa % sb;
                return {1'b0, r[31:0], q[31:0]};
            end
        endcase
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        logic [64:0] e;
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 96'(1), 96'(0));
            end else begin
                e = exp_q.pop_front();
                chk("result", {31'd0, div_by_zero, hi, lo}, {31'd0, e});
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("idle_timeout", 96'(n), 96'(0));
    endtask

    // Starts just after an accepting edge; checks latency, busy and hi/lo hold until done
    task automatic wait_done(input bit intrude);
        int n = 0;
        bit busy_ok = 1'b1;
        logic [W-1:0] h0, l0;
        h0 = hi;
        l0 = lo;
        while (n < 200) begin
            @(posedge clk);
            #1;
            n++;
            if (done) break;
            if (!busy || hi !== h0 || lo !== l0) busy_ok = 1'b0;
            if (intrude && n == 9) begin
                start = 1'b1;
                op    = 2'($urandom_range(0, 3));
                A     = $urandom;
                B     = $urandom;
            end else if (intrude && n == 10) begin
                start = 1'b0;
            end
        end
        chk("latency", 96'(n), 96'(W + 1));
        chk("busy_hold", {95'd0, busy_ok}, 96'(1));
        chk("busy_low_at_done", {95'd0, busy}, 96'(0));
    endtask

    task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b, input bit intrude);
        wait_idle();
        start = 1'b1;
        op    = o;
        A     = a;
        B     = b;
        exp_q.push_back(model(o, a, b));
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(intrude);
    endtask

    initial begin
        logic [1:0]   ro;
        logic [W-1:0] ra, rb;
        rst_n = 1'b0;
        start = 1'b0;
        op    = 2'd0;
        A     = '0;
        B     = '0;
`ifdef MDU_HILO_WRITE_EN
        hilo_we  = 1'b0;
        hilo_sel = 1'b0;
        hilo_wd  = '0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", {29'd0, busy, done, div_by_zero, hi, lo}, 96'(0));
        @(negedge clk);
        rst_n = 1'b1;

        issue(2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        issue(2'd1, 32'hFFFFFFFD, 32'h00000005, 1'b0);
        issue(2'd1, 32'h80000000, 32'h80000000, 1'b0);
        issue(2'd3, 32'hFFFFFFF9, 32'h00000002, 1'b0);
        issue(2'd2, 32'd100, 32'd7, 1'b0);
        issue(2'd2, 32'h00000064, 32'h00000000, 1'b0);
        issue(2'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        issue(2'd3, 32'h00000007, 32'hFFFFFFFE, 1'b0);
        issue(2'd0, 32'h12345678, 32'h9ABCDEF0, 1'b1);

        // start held high through done: second op accepted in the done cycle
        wait_idle();
        start = 1'b1;
        op    = 2'd1;
        A     = 32'hFFFFFFF0;
        B     = 32'h00000003;
        exp_q.push_back(model(2'd1, 32'hFFFFFFF0, 32'h00000003));
        exp_q.push_back(model(2'd3, 32'h80000001, 32'h00000010));
        @(posedge clk);
        #1;
        op = 2'd3;
        A  = 32'h80000001;
        B  = 32'h00000010;
        wait_done(1'b0);
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("b2b_accept", {95'd0, busy}, 96'(1));
        wait_done(1'b0);

        for (int i = 0; i < 30; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 20));
                2:       rb = 32'hFFFFFFFF;
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 3) == 0) ra = 32'($urandom_range(0, 1000));
            issue(ro, ra, rb, 1'b0);
        end

        // reset in the middle of a divide aborts with no done pulse
        wait_idle();
        start = 1'b1;
        op    = 2'd3;
        A     = 32'h7654321F;
        B     = 32'h00000013;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (15) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("reset_mid_op", {29'd0, busy, done, div_by_zero, hi, lo}, 96'(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);

`ifdef MDU_HILO_WRITE_EN
        hilo_we  = 1'b1;
        hilo_sel = 1'b1;
        hilo_wd  = 32'h12345678;
        @(posedge clk);
        #1;
        hilo_we = 1'b0;
        chk("mthi", {63'd0, done, hi}, {64'd0, 32'h12345678});
        @(negedge clk);
        hilo_we  = 1'b1;
        hilo_sel = 1'b0;
        hilo_wd  = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        hilo_we = 1'b0;
        chk("mtlo", {31'd0, done, hi, lo}, {32'd0, 32'h12345678, 32'hCAFEF00D});
`endif

        issue(2'd2, 32'd100, 32'd7, 1'b0);
        repeat (3) @(negedge clk);
        chk("queue_drained", 96'(exp_q.size()), 96'(0));
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
